// File: rtl/fwu_scoreboard_pkg.sv
// Shared widths and helpers for the forwarding unit with long-latency scoreboard.
package fwu_scoreboard_pkg;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned PEND_W  = 6;

  typedef logic [REG_AW-1:0] regAddrT;

  // Bit offset of element idx in a flattened bus of w-bit elements
  function automatic int unsigned sliceLsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/fwu_scoreboard_port_sel.sv
// One operand read port: stage-priority forwarding, completion bypass and hazard flag.
module fwu_port_sel
  import fwu_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic [NUM_STAGES*XLEN-1:0]   fwdData,
  input  logic [NUM_STAGES*REG_AW-1:0] fwdAddr,
  input  logic [NUM_STAGES-1:0]        fwdWen,
  input  logic [NUM_STAGES-1:0]        fwdReady,
  input  regAddrT                      rsAddr,
  input  logic                         rsRen,
  input  logic [XLEN-1:0]              rfData,
  input  logic                         cplValid,
  input  regAddrT                      cplRd,
  input  logic [XLEN-1:0]              cplData,
  input  logic                         flush,
  input  logic [REG_NUM-1:0]           busyVec,
  output logic [XLEN-1:0]              rsData,
  output logic                         hazard
);

  logic            hit;
  logic            hitReady;
  logic [XLEN-1:0] hitData;

  // Scan oldest to youngest so the youngest matching stage overwrites
  always_comb begin
    hit      = 1'b0;
    hitReady = 1'b0;
    hitData  = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (fwdWen[s] && (fwdAddr[sliceLsb(s, REG_AW) +: REG_AW] == rsAddr)) begin
        hit      = 1'b1;
        hitReady = fwdReady[s];
        hitData  = fwdData[sliceLsb(s, XLEN) +: XLEN];
      end
    end
  end

  always_comb begin
    rsData = rfData;
    hazard = 1'b0;
    if (!rsRen || (rsAddr == '0)) begin
      rsData = '0;
    end else if (hit) begin
      rsData = hitReady ? hitData : '0;
      hazard = !hitReady;
    end else if (cplValid && (cplRd == rsAddr) && !flush) begin
      rsData = cplData;
    end else if (busyVec[rsAddr]) begin
      hazard = 1'b1;
    end
  end

endmodule

// File: rtl/fwu_scoreboard.sv
// Operand forwarding for NUM_RD ports plus a busy scoreboard for long-latency writers.
module fwu_scoreboard
  import fwu_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_STAGES*XLEN-1:0]   FwdDataIn,
  input  logic [NUM_STAGES*REG_AW-1:0] FwdAddrIn,
  input  logic [NUM_STAGES-1:0]        FwdWenIn,
  input  logic [NUM_STAGES-1:0]        FwdReadyIn,
  input  logic [NUM_RD*REG_AW-1:0]     RsAddrIn,
  input  logic [NUM_RD-1:0]            RsRenIn,
  input  logic [NUM_RD*XLEN-1:0]       RsDataRegFileIn,
  input  logic                         IssueValidIn,
  input  logic                         IssueWenIn,
  input  logic                         IssueLongIn,
  input  logic [REG_AW-1:0]            IssueRdIn,
  input  logic                         CplValidIn,
  input  logic [REG_AW-1:0]            CplRdIn,
  input  logic [XLEN-1:0]              CplDataIn,
  input  logic                         FlushIn,
  output logic [NUM_RD*XLEN-1:0]       RsDataOut,
  output logic                         StallOut,
  output logic [REG_NUM-1:0]           BusyVecOut,
  output logic [PEND_W-1:0]            PendCntOut,
  output logic                         ErrOut
);

  logic [REG_NUM-1:0] busyQ;
  logic [PEND_W-1:0]  pendCntQ;
  logic               errQ;
  logic [NUM_RD-1:0]  portHaz;

  logic               waw;
  logic               limit;
  logic               accept;
  logic               setEn;
  logic               clrEn;
  logic               cplErr;
  logic [REG_NUM-1:0] setVec;
  logic [REG_NUM-1:0] clrVec;

  for (genvar p = 0; p < NUM_RD; p++) begin : gPort
    fwu_port_sel #(
      .XLEN       (XLEN),
      .NUM_STAGES (NUM_STAGES)
    ) uSel (
      .fwdData  (FwdDataIn),
      .fwdAddr  (FwdAddrIn),
      .fwdWen   (FwdWenIn),
      .fwdReady (FwdReadyIn),
      .rsAddr   (RsAddrIn[p*REG_AW +: REG_AW]),
      .rsRen    (RsRenIn[p]),
      .rfData   (RsDataRegFileIn[p*XLEN +: XLEN]),
      .cplValid (CplValidIn),
      .cplRd    (CplRdIn),
      .cplData  (CplDataIn),
      .flush    (FlushIn),
      .busyVec  (busyQ),
      .rsData   (RsDataOut[p*XLEN +: XLEN]),
      .hazard   (portHaz[p])
    );
  end

  // Hazard detection, issue acceptance and scoreboard set/clear vectors
  always_comb begin
    setVec = '0;
    clrVec = '0;
    waw    = IssueWenIn && (IssueRdIn != '0) && busyQ[IssueRdIn]
             && !(CplValidIn && (CplRdIn == IssueRdIn));
    limit  = IssueLongIn && IssueWenIn && (IssueRdIn != '0)
             && (pendCntQ == PEND_W'(MAX_PENDING)) && !CplValidIn;
    StallOut = rst_n && IssueValidIn && ((|portHaz) || waw || limit);
    accept = IssueValidIn && !StallOut && !FlushIn;
    setEn  = accept && IssueLongIn && IssueWenIn && (IssueRdIn != '0);
    clrEn  = CplValidIn && !FlushIn && busyQ[CplRdIn];
    cplErr = CplValidIn && !FlushIn && !busyQ[CplRdIn];
    if (setEn) setVec[IssueRdIn] = 1'b1;
    if (clrEn) clrVec[CplRdIn]   = 1'b1;
  end

  // Clear-then-set ordering lets a same-register set win over its clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busyQ    <= '0;
      pendCntQ <= '0;
      errQ     <= 1'b0;
    end else if (FlushIn) begin
      busyQ    <= '0;
      pendCntQ <= '0;
    end else begin
      busyQ    <= (busyQ & ~clrVec) | setVec;
      pendCntQ <= pendCntQ + PEND_W'(setEn) - PEND_W'(clrEn);
      errQ     <= errQ | cplErr;
    end
  end

  assign BusyVecOut = busyQ;
  assign PendCntOut = pendCntQ;
  assign ErrOut     = errQ;

endmodule

// File: tb/tb_fwu_scoreboard.sv
// Directed bench with a per-cycle behavioural model of forwarding and the busy scoreboard.
module tb_fwu_scoreboard;

  localparam int XLEN = 64;
  localparam int NRD  = 2;
  localparam int NST  = 2;
  localparam int MAXP = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NST*XLEN-1:0]  FwdDataIn;
  logic [NST*5-1:0]     FwdAddrIn;
  logic [NST-1:0]       FwdWenIn;
  logic [NST-1:0]       FwdReadyIn;
  logic [NRD*5-1:0]     RsAddrIn;
  logic [NRD-1:0]       RsRenIn;
  logic [NRD*XLEN-1:0]  RsDataRegFileIn;
  logic                 IssueValidIn;
  logic                 IssueWenIn;
  logic                 IssueLongIn;
  logic [4:0]           IssueRdIn;
  logic                 CplValidIn;
  logic [4:0]           CplRdIn;
  logic [XLEN-1:0]      CplDataIn;
  logic                 FlushIn;
  logic [NRD*XLEN-1:0]  RsDataOut;
  logic                 StallOut;
  logic [31:0]          BusyVecOut;
  logic [5:0]           PendCntOut;
  logic                 ErrOut;

  fwu_scoreboard #(
    .XLEN(XLEN), .NUM_RD(NRD), .NUM_STAGES(NST), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .FwdDataIn(FwdDataIn), .FwdAddrIn(FwdAddrIn), .FwdWenIn(FwdWenIn), .FwdReadyIn(FwdReadyIn),
    .RsAddrIn(RsAddrIn), .RsRenIn(RsRenIn), .RsDataRegFileIn(RsDataRegFileIn),
    .IssueValidIn(IssueValidIn), .IssueWenIn(IssueWenIn), .IssueLongIn(IssueLongIn),
    .IssueRdIn(IssueRdIn), .CplValidIn(CplValidIn), .CplRdIn(CplRdIn), .CplDataIn(CplDataIn),
    .FlushIn(FlushIn), .RsDataOut(RsDataOut), .StallOut(StallOut), .BusyVecOut(BusyVecOut),
    .PendCntOut(PendCntOut), .ErrOut(ErrOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;
  bit checkEn = 0;

  // Reference state: which registers have an outstanding long writer, and the sticky error
  bit mBusy[32];
  bit mErr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mCount();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mBusy[i]);
    return c;
  endfunction

  function automatic void expPort(input int p, output logic [XLEN-1:0] d, output bit h);
    logic [4:0] a;
    a = RsAddrIn[p*5 +: 5];
    d = '0;
    h = 0;
    if (!RsRenIn[p] || a == 5'd0) return;
    for (int s = 0; s < NST; s++) begin
      if (FwdWenIn[s] && FwdAddrIn[s*5 +: 5] == a) begin
        if (FwdReadyIn[s]) d = FwdDataIn[s*XLEN +: XLEN];
        else h = 1;
        return;
      end
    end
    if (CplValidIn && CplRdIn == a && !FlushIn) d = CplDataIn;
    else if (mBusy[a]) h = 1;
    else d = RsDataRegFileIn[p*XLEN +: XLEN];
  endfunction

  function automatic bit expStall();
    logic [XLEN-1:0] d;
    bit h;
    bit anyH = 0;
    bit waw;
    bit lim;
    for (int p = 0; p < NRD; p++) begin
      expPort(p, d, h);
      anyH |= h;
    end
    waw = IssueWenIn && IssueRdIn != 0 && mBusy[IssueRdIn] && !(CplValidIn && CplRdIn == IssueRdIn);
    lim = IssueLongIn && IssueWenIn && IssueRdIn != 0 && mCount() == MAXP && !CplValidIn;
    return rst_n && IssueValidIn && (anyH || waw || lim);
  endfunction

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (checkEn) begin
      logic [XLEN-1:0] d;
      logic [31:0] bv;
      bit h;
      for (int p = 0; p < NRD; p++) begin
        expPort(p, d, h);
        if (!h) chk($sformatf("model RsData[%0d]", p), RsDataOut[p*XLEN +: XLEN], d);
      end
      for (int i = 0; i < 32; i++) bv[i] = mBusy[i];
      chk("model Stall", 64'(StallOut), 64'(expStall()));
      chk("model BusyVec", 64'(BusyVecOut), 64'(bv));
      chk("model PendCnt", 64'(PendCntOut), 64'(mCount()));
      chk("model Err", 64'(ErrOut), 64'(mErr));
    end
  end

  // Model state update on each rising edge
  always @(posedge clk) begin
    bit acc;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mBusy[i] = 0;
      mErr = 0;
    end else if (FlushIn) begin
      for (int i = 0; i < 32; i++) mBusy[i] = 0;
    end else begin
      acc = IssueValidIn && !expStall();
      if (CplValidIn) begin
        if (CplRdIn != 0 && mBusy[CplRdIn]) mBusy[CplRdIn] = 0;
        else mErr = 1;
      end
      if (acc && IssueLongIn && IssueWenIn && IssueRdIn != 0) mBusy[IssueRdIn] = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic setStage(input int s, input logic [4:0] rd, input logic [XLEN-1:0] d,
                          input logic wen, input logic rdy);
    FwdAddrIn[s*5 +: 5]       = rd;
    FwdDataIn[s*XLEN +: XLEN] = d;
    FwdWenIn[s]               = wen;
    FwdReadyIn[s]             = rdy;
  endtask

  task automatic setRs(input int p, input logic [4:0] a, input logic ren, input logic [XLEN-1:0] rf);
    RsAddrIn[p*5 +: 5]              = a;
    RsRenIn[p]                      = ren;
    RsDataRegFileIn[p*XLEN +: XLEN] = rf;
  endtask

  task automatic issue(input logic v, input logic wen, input logic lng, input logic [4:0] rd);
    IssueValidIn = v;
    IssueWenIn   = wen;
    IssueLongIn  = lng;
    IssueRdIn    = rd;
  endtask

  task automatic cpl(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
    CplValidIn = v;
    CplRdIn    = rd;
    CplDataIn  = d;
  endtask

  task automatic idle();
    for (int s = 0; s < NST; s++) setStage(s, 5'd0, '0, 1'b0, 1'b0);
    for (int p = 0; p < NRD; p++) setRs(p, 5'd0, 1'b0, '0);
    issue(1'b0, 1'b0, 1'b0, 5'd0);
    cpl(1'b0, 5'd0, '0);
    FlushIn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    checkEn = 1;
    // Stall must stay low under reset even with a load-use pattern present
    setStage(0, 5'd6, '0, 1'b1, 1'b0);
    setRs(0, 5'd6, 1'b1, '0);
    issue(1'b1, 1'b0, 1'b0, 5'd0);
    settle();
    chk("reset Stall", 64'(StallOut), 64'd0);
    chk("reset BusyVec", 64'(BusyVecOut), 64'd0);
    chk("reset PendCnt", 64'(PendCntOut), 64'd0);
    chk("reset Err", 64'(ErrOut), 64'd0);

    // Stage priority
    cyc();
    rst_n = 1'b1;
    idle();
    issue(1'b1, 1'b0, 1'b0, 5'd0);
    setStage(0, 5'd5, 64'hAA, 1'b1, 1'b1);
    setStage(1, 5'd5, 64'hBB, 1'b1, 1'b1);
    setRs(0, 5'd5, 1'b1, 64'h77);
    settle();
    chk("prio stage0", RsDataOut[0 +: XLEN], 64'hAA);
    chk("prio stall", 64'(StallOut), 64'd0);
    cyc();
    setStage(0, 5'd5, 64'hAA, 1'b0, 1'b1);
    settle();
    chk("prio stage1", RsDataOut[0 +: XLEN], 64'hBB);
    cyc();
    setStage(1, 5'd5, 64'hBB, 1'b0, 1'b1);
    settle();
    chk("prio regfile", RsDataOut[0 +: XLEN], 64'h77);

    // Load-use
    cyc();
    idle();
    issue(1'b1, 1'b0, 1'b0, 5'd0);
    setStage(0, 5'd7, '0, 1'b1, 1'b0);
    setRs(1, 5'd7, 1'b1, 64'h99);
    settle();
    chk("loaduse stall", 64'(StallOut), 64'd1);
    cyc();
    setStage(0, 5'd7, 64'h1234, 1'b1, 1'b1);
    settle();
    chk("loaduse release", 64'(StallOut), 64'd0);
    chk("loaduse data", RsDataOut[XLEN +: XLEN], 64'h1234);

    // Scoreboard RAW with same-cycle completion bypass
    cyc();
    idle();
    issue(1'b1, 1'b1, 1'b1, 5'd9);
    cyc();
    idle();
    settle();
    chk("raw busy9", 64'(BusyVecOut[9]), 64'd1);
    chk("raw pend1", 64'(PendCntOut), 64'd1);
    cyc();
    issue(1'b1, 1'b0, 1'b0, 5'd0);
    setRs(0, 5'd9, 1'b1, 64'h11);
    settle();
    chk("raw stall", 64'(StallOut), 64'd1);
    cyc();
    cpl(1'b1, 5'd9, 64'h55);
    settle();
    chk("raw bypass", RsDataOut[0 +: XLEN], 64'h55);
    chk("raw nostall", 64'(StallOut), 64'd0);
    cyc();
    idle();
    settle();
    chk("raw cleared", 64'(BusyVecOut[9]), 64'd0);
    chk("raw pend0", 64'(PendCntOut), 64'd0);

    // Pending limit and WAW
    for (int i = 1; i <= 4; i++) begin
      cyc();
      issue(1'b1, 1'b1, 1'b1, 5'(i));
    end
    cyc();
    idle();
    settle();
    chk("limit pend4", 64'(PendCntOut), 64'd4);
    cyc();
    issue(1'b1, 1'b1, 1'b1, 5'd5);
    settle();
    chk("limit stall", 64'(StallOut), 64'd1);
    cyc();
    settle();
    chk("limit held", 64'(StallOut), 64'd1);
    cyc();
    cpl(1'b1, 5'd2, 64'h22);
    settle();
    chk("limit accept", 64'(StallOut), 64'd0);
    cyc();
    idle();
    settle();
    chk("limit pend after", 64'(PendCntOut), 64'd4);
    chk("limit busy vec", 64'(BusyVecOut), 64'h3A);
    cyc();
    issue(1'b1, 1'b1, 1'b0, 5'd3);
    settle();
    chk("waw stall", 64'(StallOut), 64'd1);

    // x0 handling and completion errors
    cyc();
    idle();
    issue(1'b1, 1'b1, 1'b1, 5'd0);
    settle();
    chk("x0 issue nostall", 64'(StallOut), 64'd0);
    cyc();
    idle();
    setStage(0, 5'd0, 64'hDEAD, 1'b1, 1'b1);
    setRs(0, 5'd0, 1'b1, 64'hBEEF);
    settle();
    chk("x0 pend unchanged", 64'(PendCntOut), 64'd4);
    chk("x0 read zero", RsDataOut[0 +: XLEN], 64'd0);
    cyc();
    idle();
    cpl(1'b1, 5'd12, 64'hC);
    settle();
    chk("err not yet", 64'(ErrOut), 64'd0);
    cyc();
    idle();
    settle();
    chk("err set", 64'(ErrOut), 64'd1);
    cyc();
    settle();
    chk("err sticky", 64'(ErrOut), 64'd1);

    // Flush with simultaneous long issue
    cyc();
    cpl(1'b1, 5'd1, 64'h1);
    cyc();
    idle();
    settle();
    chk("flush pre pend3", 64'(PendCntOut), 64'd3);
    cyc();
    FlushIn = 1'b1;
    issue(1'b1, 1'b1, 1'b1, 5'd8);
    cyc();
    idle();
    settle();
    chk("flush busy", 64'(BusyVecOut), 64'd0);
    chk("flush pend", 64'(PendCntOut), 64'd0);

    // Reset mid-operation, then a stale completion
    cyc();
    issue(1'b1, 1'b1, 1'b1, 5'd10);
    cyc();
    idle();
    settle();
    chk("pre reset busy10", 64'(BusyVecOut[10]), 64'd1);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    settle();
    chk("post reset busy", 64'(BusyVecOut), 64'd0);
    chk("post reset pend", 64'(PendCntOut), 64'd0);
    chk("post reset err", 64'(ErrOut), 64'd0);
    cyc();
    cpl(1'b1, 5'd10, 64'hA);
    cyc();
    idle();
    settle();
    chk("stale cpl err", 64'(ErrOut), 64'd1);
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/fwu_scoreboard.md
Name: fwu_scoreboard

Overview:
- Parametrised successor to the two-port EX/MEM + MEM/WB forwarding unit.
- Forwards operand data for NUM_RD read ports from NUM_STAGES pipeline writeback stages plus a long-latency completion bus.
- Tracks in-flight long-latency writers (load-miss, mul/div) in a 32-entry busy scoreboard, and raises a stall for load-use, RAW-on-busy, WAW-on-busy and pending-limit hazards.
- Sits between the regfile read in ID and the ID/EX register.

Parameters:
- XLEN, 64, data width.
- NUM_RD, 2, number of operand read ports.
- NUM_STAGES, 2, number of forwarding stages; index 0 is the youngest (EX/MEM).
- MAX_PENDING, 4, maximum simultaneous long-latency writers (1..31).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- FwdDataIn  in  NUM_STAGES*XLEN  per-stage rd data
- FwdAddrIn  in  NUM_STAGES*5  per-stage rd address
- FwdWenIn  in  NUM_STAGES  per-stage rd write enable
- FwdReadyIn  in  NUM_STAGES  stage data valid (0 = load data not yet available)
- RsAddrIn  in  NUM_RD*5  source addresses
- RsRenIn  in  NUM_RD  source read enables
- RsDataRegFileIn  in  NUM_RD*XLEN  regfile read data
- IssueValidIn  in  1  ID instruction requests to enter EX
- IssueWenIn  in  1  issuing instruction writes rd
- IssueLongIn  in  1  issuing instruction is a long-latency writer
- IssueRdIn  in  5  issuing instruction rd
- CplValidIn  in  1  long-latency result valid
- CplRdIn  in  5  completion rd
- CplDataIn  in  XLEN  completion data
- FlushIn  in  1  pipeline flush; the long unit is flushed simultaneously
- RsDataOut  out  NUM_RD*XLEN  forwarded operands
- StallOut  out  1  hold ID/IF; issue not accepted
- BusyVecOut  out  32  scoreboard busy bits (bit 0 always 0)
- PendCntOut  out  6  number of busy bits set
- ErrOut  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clk. rst_n sampled on the rising edge. While rst_n=0, StallOut=0.
- Reset values: BusyVecOut=0, PendCntOut=0, ErrOut=0.
- Operand select (combinational, zero latency), per port p:
  - RsRenIn[p]=0 or RsAddrIn[p]=0: output 0 (x0), no hazard.
  - Otherwise, the lowest-index stage s with FwdWenIn[s] && FwdAddrIn[s]==addr wins. If FwdReadyIn[s]=1, output FwdDataIn[s]. If FwdReadyIn[s]=0, output is don't-care and port hazard=1 (load-use).
  - Otherwise, if CplValidIn && CplRdIn==addr && !FlushIn: output CplDataIn, no hazard (same-cycle bypass).
  - Otherwise, if busy[addr]: port hazard=1.
  - Otherwise: output RsDataRegFileIn[p].
- Stall conditions: StallOut = IssueValidIn && (any port hazard || WAW || LIMIT).
  - WAW = IssueWenIn && IssueRdIn!=0 && busy[IssueRdIn] && !(CplValidIn && CplRdIn==IssueRdIn).
  - LIMIT = IssueLongIn && IssueWenIn && IssueRdIn!=0 && PendCntOut==MAX_PENDING && !CplValidIn.
- Issue handshake: an issue is accepted when IssueValidIn && !StallOut && !FlushIn.
- Scoreboard update on each rising edge, with rst_n=1:
  - FlushIn=1: busy <= 0, PendCntOut <= 0. Same-cycle issue and completion are ignored.
  - Clear: CplValidIn clears busy[CplRdIn].
  - Set: an accepted long issue with IssueWenIn and rd!=0 sets busy[IssueRdIn].
  - Same register cleared and set in the same cycle: set wins.
  - PendCntOut += set - clear, registered, and equal to popcount(busy) at all times.
- Errors: completion to a non-busy register or to rd=0 sets ErrOut (sticky until reset). Busy is unchanged and the counter is not decremented.
- Long ops never assert FwdWenIn in pipeline stages; their result arrives only via the completion bus.
- Reset mid-operation: all pending entries are dropped. Completions arriving after reset raise ErrOut.

Decomposition:
- defines.v gets: REG_NUM 32, RegFileAddr width 5, pending-counter width 6, and stage index macros for slicing the flattened buses.
- One sub-module, fwu_port_sel: per-port priority select and hazard flag, instantiated NUM_RD times via generate.
- Scoreboard and stall logic stay in the top module.

Test Plan:
- Priority: stage0 {rd=5, data=0xAA, ready=1} and stage1 {rd=5, data=0xBB}, RsAddrIn[0]=5 -> RsDataOut[0]=0xAA, StallOut=0. Drop stage0 -> 0xBB. Both gone -> regfile value.
- Load-use: stage0 {rd=7, ready=0}, port1 reads x7, IssueValidIn=1 -> StallOut=1. Next cycle ready=1, data=0x1234 -> StallOut=0, RsDataOut[1]=0x1234.
- Scoreboard RAW: long issue rd=9 accepted -> BusyVecOut[9]=1, PendCntOut=1. Read x9 -> StallOut=1. CplValidIn rd=9 data=0x55 in the same cycle as the read -> RsDataOut=0x55, StallOut=0. Next cycle busy[9]=0, PendCntOut=0.
- Limit and WAW: 4 long issues to x1..x4 -> PendCntOut=4. 5th long issue stalls and is accepted the cycle x2 completes. Short issue with rd=3 while busy -> StallOut=1.
- x0 and errors: long issue rd=0 -> no busy bit set. Read x0 with stage rd=0 -> output 0. Completion to x12 when not busy -> ErrOut=1 and held.
- Flush/reset: 3 pending entries, FlushIn=1 together with a long issue to x8 -> busy=0 and PendCntOut=0 next cycle, x8 not set. Assert rst_n=0 for 1 cycle -> all outputs at reset values.
